lenet_axil_regs: RTL and testbench

AXI4-Lite slave register file for the LeNet accelerator; it answers the host/VIP master driving the register map below. It decodes single-beat writes into a core enable, a soft reset and an indexed load stream for weights, biases and the input feature map. It captures the core's done pulse and classification result for polling reads. It sits between the AXI4-Lite interconnect port and the LeNet core.

---
 rtl/lenet_axil_regs_if.sv | 38 +++
 rtl/lenet_axil_regs.sv | 183 ++++++++++++++++++
 tb/tb_lenet_axil_regs.sv | 516 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lenet_axil_regs_if.sv
// AXI4-Lite bus bundle for the LeNet accelerator register file.
// The master modport is the host side, the slave modport the register file.
interface lenet_axil_regs_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/lenet_axil_regs.sv
// AXI4-Lite register file and load stream for the LeNet core.
// LENET_AXIL_DONE_CLR_ON_READ_EN: a read of RESULT also clears done.
module lenet_axil_regs #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WEIGHT = 3220,
  parameter int NUM_BIAS   = 10,
  parameter int NUM_FMAP   = 784,
  parameter int IDX_WIDTH  = 12
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  lenet_axil_regs_if.slave      s_axi,
  output logic                  core_ce,
  output logic                  core_srst,
  output logic                  ld_valid,
  output logic [1:0]            ld_sel,
  output logic [IDX_WIDTH-1:0]  ld_idx,
  output logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  core_done,
  input  logic [3:0]            core_result
);

  localparam int WW = ADDR_WIDTH - 2;
  typedef logic [WW-1:0] word_t;
  typedef logic [IDX_WIDTH-1:0] cnt_t;

  localparam word_t R_CTRL   = word_t'(0);
  localparam word_t R_WEIGHT = word_t'(1);
  localparam word_t R_BIAS   = word_t'(2);
  localparam word_t R_FMAP   = word_t'(3);
  localparam word_t R_STAT   = word_t'(4);
  localparam word_t R_DONE   = word_t'(5);
  localparam word_t R_RESULT = word_t'(6);
  localparam word_t R_SRST   = word_t'(7);

  word_t waddr, raddr;
  logic wr_fire, rd_fire;
  cnt_t cnt_w, cnt_b, cnt_f, push_cnt;
  logic full_w, full_b, full_f;
  logic push_hit, push_full, push_ok, push_err;
  logic [1:0] push_sel;
  logic ce_q, srst_q, done_q, clr, rd_clr, strb_all;
  logic [3:0] result_q;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic unused_ok;

  assign waddr    = s_axi.awaddr[ADDR_WIDTH-1:2];
  assign raddr    = s_axi.araddr[ADDR_WIDTH-1:2];
  assign wr_fire  = s_axi.awready & s_axi.awvalid & s_axi.wvalid;
  assign rd_fire  = s_axi.arready & s_axi.arvalid;
  assign strb_all = &s_axi.wstrb;
  assign full_w   = cnt_w == cnt_t'(NUM_WEIGHT);
  assign full_b   = cnt_b == cnt_t'(NUM_BIAS);
  assign full_f   = cnt_f == cnt_t'(NUM_FMAP);
  assign core_ce   = ce_q;
  assign core_srst = srst_q;
  assign s_axi.rresp = 2'b00;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot,
                       s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  always_comb begin
    push_hit  = 1'b0;
    push_sel  = 2'd0;
    push_cnt  = cnt_w;
    push_full = full_w;
    unique case (1'b1)
      (waddr == R_WEIGHT): push_hit = 1'b1;
      (waddr == R_BIAS): begin
        push_hit  = 1'b1;
        push_sel  = 2'd1;
        push_cnt  = cnt_b;
        push_full = full_b;
      end
      (waddr == R_FMAP): begin
        push_hit  = 1'b1;
        push_sel  = 2'd2;
        push_cnt  = cnt_f;
        push_full = full_f;
      end
      default: ;
    endcase
  end

  assign push_ok  = wr_fire & push_hit & strb_all & ~push_full;
  assign push_err = push_hit & (~strb_all | push_full);
  // soft reset clears on the write edge and every cycle it stays set
  assign clr = srst_q | (wr_fire & (waddr == R_SRST)
                         & s_axi.wstrb[0] & s_axi.wdata[0]);

`ifdef LENET_AXIL_DONE_CLR_ON_READ_EN
  assign rd_clr = rd_fire & (raddr == R_RESULT);
`else
  assign rd_clr = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (raddr == R_CTRL):   rd_mux[0]   = ce_q;
      (raddr == R_STAT):   rd_mux[2:0] = {full_f, full_b, full_w};
      (raddr == R_DONE):   rd_mux[0]   = done_q;
      (raddr == R_RESULT): rd_mux[3:0] = result_q;
      (raddr == R_SRST):   rd_mux[0]   = srst_q;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= 2'b00;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rdata   <= '0;
      ce_q     <= 1'b0;
      srst_q   <= 1'b0;
      ld_valid <= 1'b0;
      ld_sel   <= 2'd0;
      ld_idx   <= '0;
      ld_data  <= '0;
      cnt_w    <= '0;
      cnt_b    <= '0;
      cnt_f    <= '0;
      done_q   <= 1'b0;
      result_q <= 4'd0;
    end else begin
      s_axi.awready <= s_axi.awvalid & s_axi.wvalid
                       & ~s_axi.bvalid & ~s_axi.awready;
      s_axi.wready  <= s_axi.awvalid & s_axi.wvalid
                       & ~s_axi.bvalid & ~s_axi.awready;
      if (s_axi.bvalid & s_axi.bready)
        s_axi.bvalid <= 1'b0;
      if (wr_fire) begin
        s_axi.bvalid <= 1'b1;
        s_axi.bresp  <= push_err ? 2'b10 : 2'b00;
      end

      ld_valid <= push_ok;
      if (push_ok) begin
        ld_sel  <= push_sel;
        ld_idx  <= push_cnt;
        ld_data <= s_axi.wdata;
      end

      if (wr_fire & s_axi.wstrb[0]) begin
        if (waddr == R_CTRL) ce_q   <= s_axi.wdata[0];
        if (waddr == R_SRST) srst_q <= s_axi.wdata[0];
      end

      if (clr) begin
        cnt_w <= '0;
        cnt_b <= '0;
        cnt_f <= '0;
      end else if (push_ok) begin
        if (push_sel == 2'd0) cnt_w <= cnt_w + 1'b1;
        if (push_sel == 2'd1) cnt_b <= cnt_b + 1'b1;
        if (push_sel == 2'd2) cnt_f <= cnt_f + 1'b1;
      end

      if (clr) begin
        done_q   <= 1'b0;
        result_q <= 4'd0;
      end else if (core_done) begin
        done_q   <= 1'b1;
        result_q <= core_result;
      end else if (rd_clr) begin
        done_q   <= 1'b0;
      end

      s_axi.arready <= s_axi.arvalid & ~s_axi.rvalid & ~s_axi.arready;
      if (s_axi.rvalid & s_axi.rready)
        s_axi.rvalid <= 1'b0;
      if (rd_fire) begin
        s_axi.rvalid <= 1'b1;
        s_axi.rdata  <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_lenet_axil_regs.sv
// Randomised self-checking bench for lenet_axil_regs.
// A register-map-level model predicts responses, reads and load strobes.
module tb_lenet_axil_regs;

  logic        clk = 1'b0;
  logic        ARESET = 1'b1;
  logic        core_ce, core_srst, ld_valid;
  logic [1:0]  ld_sel;
  logic [11:0] ld_idx;
  logic [31:0] ld_data;
  logic        core_done = 1'b0;
  logic [3:0]  core_result = 4'd0;

  lenet_axil_regs_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  lenet_axil_regs dut (
    .ACLK(clk),
    .ARESET(ARESET),
    .s_axi(bus),
    .core_ce(core_ce),
    .core_srst(core_srst),
    .ld_valid(ld_valid),
    .ld_sel(ld_sel),
    .ld_idx(ld_idx),
    .ld_data(ld_data),
    .core_done(core_done),
    .core_result(core_result)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // model of the register map
  int   cnt[3];
  int   num[3] = '{3220, 10, 784};
  bit   m_ce, m_done;
  logic [3:0] m_res;

  logic [45:0] strobe_q[$];

  always @(posedge clk)
    if (ld_valid) strobe_q.push_back({ld_sel, ld_idx, ld_data});

  task automatic model_reset();
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    m_ce = 1'b0;
    m_done = 1'b0;
    m_res = 4'd0;
  endtask

  task automatic pulse_done(input logic [3:0] r);
    @(posedge clk); #1;
    core_done = 1'b1;
    core_result = r;
    @(posedge clk); #1;
    core_done = 1'b0;
    m_done = 1'b1;
    m_res = r;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit with_done,
                           output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    bus.awaddr = a;
    bus.awvalid = 1'b1;
    bus.wdata = d;
    bus.wstrb = s;
    bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    n = 0;
    while (!(bus.awready && bus.wready) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      vectors++; errors++;
      $display("FAIL write_accept_timeout addr=%h awready=%b required 1", a, bus.awready);
    end
    if (with_done) begin
      core_done = 1'b1;
      core_result = 4'd5;
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    core_done = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      vectors++; errors++;
      $display("FAIL bvalid_timeout addr=%h bvalid=%b required 1", a, bus.bvalid);
    end
    resp = bus.bresp;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    int n;
    @(posedge clk); #1;
    bus.araddr = a;
    bus.arvalid = 1'b1;
    bus.rready = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      vectors++; errors++;
      $display("FAIL read_accept_timeout addr=%h arready=%b required 1", a, bus.arready);
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      vectors++; errors++;
      $display("FAIL rvalid_timeout addr=%h rvalid=%b required 1", a, bus.rvalid);
    end
    d = bus.rdata;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [89:0] obs;
    repeat (3) @(posedge clk);
    #1;
    for (int pass = 0; pass < 2; pass++) begin
      obs = {bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.arready,
             bus.rvalid, bus.rdata, bus.rresp, core_ce, core_srst,
             ld_valid, ld_sel, ld_idx, ld_data};
      vectors++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_state pass=%0d got=%h required 0", pass, obs);
      end
      if (pass == 0) begin
        @(negedge clk);
        ARESET = 1'b0;
        @(posedge clk); #1;
      end
    end
    model_reset();
  endtask

  task automatic test_srst_ctrl();
    logic [1:0] resp;
    logic [31:0] rd;
    logic [4:0] ra[3] = '{5'h10, 5'h14, 5'h18};
    axi_write(5'h1C, 32'd1, 4'hF, 1'b0, resp);
    vectors++;
    if (resp !== 2'b00 || core_srst !== 1'b1) begin
      errors++;
      $display("FAIL srst_set resp=%b srst=%b required 00/1", resp, core_srst);
    end
    axi_write(5'h1C, 32'd0, 4'hF, 1'b0, resp);
    vectors++;
    if (resp !== 2'b00 || core_srst !== 1'b0) begin
      errors++;
      $display("FAIL srst_clear resp=%b srst=%b required 00/0", resp, core_srst);
    end
    axi_write(5'h00, 32'd1, 4'hF, 1'b0, resp);
    m_ce = 1'b1;
    vectors++;
    if (resp !== 2'b00 || core_ce !== 1'b1) begin
      errors++;
      $display("FAIL ctrl_ce resp=%b ce=%b required 00/1", resp, core_ce);
    end
    for (int i = 0; i < 3; i++) begin
      axi_read(ra[i], rd);
      vectors++;
      if (rd !== 32'd0) begin
        errors++;
        $display("FAIL status_zero addr=%h got=%h required 0", ra[i], rd);
      end
    end
    vectors++;
    if (strobe_q.size() != 0) begin
      errors++;
      $display("FAIL stray_strobe got=%0d required 0", strobe_q.size());
    end
    strobe_q.delete();
  endtask

  task automatic test_wstrb();
    logic [1:0] resp;
    logic [31:0] d;
    d = $urandom;
    axi_write(5'h0C, d, 4'h3, 1'b0, resp);
    vectors++;
    if (resp !== 2'b10 || strobe_q.size() != 0) begin
      errors++;
      $display("FAIL partial_strobe resp=%b strobes=%0d required 10/0", resp, strobe_q.size());
    end
    strobe_q.delete();
    d = $urandom;
    axi_write(5'h0C, d, 4'hF, 1'b0, resp);
    vectors++;
    if (resp !== 2'b00 || strobe_q.size() != 1 ||
        strobe_q[0] !== {2'd2, 12'd0, d}) begin
      errors++;
      $display("FAIL fmap_first resp=%b n=%0d got=%h required 00/1/%h",
               resp, strobe_q.size(), strobe_q.size() ? strobe_q[0] : 46'd0,
               {2'd2, 12'd0, d});
    end
    strobe_q.delete();
    cnt[2] = 1;
  endtask

  task automatic test_weights();
    logic [1:0] resp;
    logic [31:0] rd;
    for (int i = 0; i < 3220; i++) begin
      axi_write(5'h04, 32'(i), 4'hF, 1'b0, resp);
      vectors++;
      if (resp !== 2'b00 || strobe_q.size() != 1 ||
          strobe_q[0] !== {2'd0, 12'(i), 32'(i)}) begin
        errors++;
        $display("FAIL weight_push i=%0d resp=%b n=%0d got=%h", i, resp,
                 strobe_q.size(), strobe_q.size() ? strobe_q[0] : 46'd0);
      end
      strobe_q.delete();
    end
    cnt[0] = 3220;
    axi_read(5'h10, rd);
    vectors++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL weight_full_flag got=%h required 1", rd);
    end
    axi_write(5'h04, 32'd3220, 4'hF, 1'b0, resp);
    vectors++;
    if (resp !== 2'b10 || strobe_q.size() != 0) begin
      errors++;
      $display("FAIL weight_overflow resp=%b strobes=%0d required 10/0", resp, strobe_q.size());
    end
    strobe_q.delete();
  endtask

  task automatic test_random();
    logic [1:0] resp, exp_resp;
    logic [31:0] d, rd, exp_d;
    logic [3:0] s;
    logic [4:0] a;
    int w, k, exp_n;
    logic [45:0] exp_s;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 7) == 0)
        pulse_done(4'($urandom_range(0, 9)));
      if ($urandom_range(0, 1) == 0) begin
        w = $urandom_range(0, 6);
        a = {3'(w), 2'($urandom)};
        d = $urandom;
        s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        exp_resp = 2'b00;
        exp_n = 0;
        exp_s = '0;
        if (w >= 1 && w <= 3) begin
          k = w - 1;
          if (s == 4'hF && cnt[k] < num[k]) begin
            exp_n = 1;
            exp_s = {2'(k), 12'(cnt[k]), d};
            cnt[k]++;
          end else begin
            exp_resp = 2'b10;
          end
        end else if (w == 0 && s[0]) begin
          m_ce = d[0];
        end
        axi_write(a, d, s, 1'b0, resp);
        vectors++;
        if (resp !== exp_resp || strobe_q.size() != exp_n ||
            (exp_n == 1 && strobe_q[0] !== exp_s) || core_ce !== m_ce) begin
          errors++;
          $display("FAIL rand_write a=%h s=%h resp=%b/%b n=%0d/%0d ce=%b/%b",
                   a, s, resp, exp_resp, strobe_q.size(), exp_n, core_ce, m_ce);
        end
        strobe_q.delete();
      end else begin
        w = $urandom_range(0, 7);
        a = {3'(w), 2'($urandom)};
        case (w)
          0: exp_d = {31'd0, m_ce};
          4: exp_d = {29'd0, cnt[2] == num[2], cnt[1] == num[1], cnt[0] == num[0]};
          5: exp_d = {31'd0, m_done};
          6: exp_d = {28'd0, m_res};
          default: exp_d = 32'd0;
        endcase
`ifdef LENET_AXIL_DONE_CLR_ON_READ_EN
        if (w == 6) m_done = 1'b0;
`endif
        axi_read(a, rd);
        vectors++;
        if (rd !== exp_d) begin
          errors++;
          $display("FAIL rand_read a=%h got=%h required %h", a, rd, exp_d);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, bad;
    logic [1:0] resp;
    @(posedge clk); #1;
    bus.awaddr = 5'h00;
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b0;
    bus.wdata = 32'd1;
    bus.wstrb = 4'hF;
    bus.bready = 1'b0;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.awready || bus.wready) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL aw_alone_accepted cycles=%0d required 0", bad);
    end
    bus.wvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (n >= 20 || bus.wready !== 1'b1) begin
      errors++;
      $display("FAIL joint_accept awready=%b wready=%b required 1/1", bus.awready, bus.wready);
    end
    @(posedge clk); #1;
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b_hold cycles_bad=%0d required 0", bad);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.bvalid !== 1'b0) begin
      errors++;
      $display("FAIL b_complete bvalid=%b required 0", bus.bvalid);
    end
    n = 0;
    while (!bus.awready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    resp = bus.bresp;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    m_ce = 1'b1;
    vectors++;
    if (n >= 20 || resp !== 2'b00 || core_ce !== 1'b1) begin
      errors++;
      $display("FAIL second_write resp=%b ce=%b required 00/1", resp, core_ce);
    end
  endtask

  task automatic test_done();
    logic [31:0] rd;
    logic [3:0] r;
    pulse_done(4'd7);
    axi_read(5'h14, rd);
    vectors++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL done_set got=%h required 1", rd);
    end
    axi_read(5'h18, rd);
`ifdef LENET_AXIL_DONE_CLR_ON_READ_EN
    m_done = 1'b0;
`endif
    vectors++;
    if (rd !== 32'd7) begin
      errors++;
      $display("FAIL result_7 got=%h required 7", rd);
    end
    axi_read(5'h14, rd);
    vectors++;
    if (rd !== {31'd0, m_done}) begin
      errors++;
      $display("FAIL done_after_result_read got=%h required %h", rd, {31'd0, m_done});
    end
    r = 4'($urandom_range(0, 9));
    pulse_done(r);
    axi_read(5'h18, rd);
    vectors++;
    if (rd !== {28'd0, r}) begin
      errors++;
      $display("FAIL result_overwrite got=%h required %h", rd, {28'd0, r});
    end
  endtask

  task automatic test_srst_vs_done();
    logic [1:0] resp;
    logic [31:0] rd;
    logic [4:0] ra[3] = '{5'h14, 5'h18, 5'h10};
    axi_write(5'h1C, 32'd1, 4'hF, 1'b1, resp);
    axi_write(5'h1C, 32'd0, 4'hF, 1'b0, resp);
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    m_done = 1'b0;
    m_res = 4'd0;
    for (int i = 0; i < 3; i++) begin
      axi_read(ra[i], rd);
      vectors++;
      if (rd !== 32'd0) begin
        errors++;
        $display("FAIL srst_clear_wins addr=%h got=%h required 0", ra[i], rd);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, bad;
    logic [31:0] rd;
    @(posedge clk); #1;
    bus.araddr = 5'h14;
    bus.arvalid = 1'b1;
    bus.rready = 1'b0;
    n = 0;
    while (!bus.arready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    vectors++;
    if (bus.rvalid !== 1'b1) begin
      errors++;
      $display("FAIL r_pending rvalid=%b required 1", bus.rvalid);
    end
    #2;
    ARESET = 1'b1;
    #1;
    vectors++;
    if (bus.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL async_drop rvalid=%b required 0", bus.rvalid);
    end
    @(negedge clk);
    @(negedge clk);
    ARESET = 1'b0;
    model_reset();
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.rvalid || bus.bvalid) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL response_after_reset cycles=%0d required 0", bad);
    end
    axi_read(5'h00, rd);
    vectors++;
    if (rd !== 32'd0 || core_ce !== 1'b0) begin
      errors++;
      $display("FAIL ctrl_after_reset got=%h ce=%b required 0/0", rd, core_ce);
    end
  endtask

  initial begin
    bus.awaddr = '0;
    bus.awprot = '0;
    bus.awvalid = 1'b0;
    bus.wdata = '0;
    bus.wstrb = '0;
    bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0;
    bus.arprot = '0;
    bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    model_reset();
    test_reset();
    test_srst_ctrl();
    test_wstrb();
    test_weights();
    test_random();
    test_back_to_back();
    test_done();
    test_srst_vs_done();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
